// File: rtl/bf16_norm.sv
// BF16 normalize-and-round stage: leading-zero normalize, then round-to-nearest-even
// and pack, as a 2-deep valid/ready pipeline with full throughput.

module lzc #(
    parameter int unsigned W  = 12,
    parameter int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  value,
    output logic [CW-1:0] count
);

    logic found;

    always_comb begin
        count = CW'(W);
        found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!found && value[W-1-i]) begin
                count = CW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

module bf16_norm #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         sign_i,
    input  logic [7:0]   exp_i,
    input  logic [W-1:0] mant_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [15:0]  data_o,
    output logic         uf_o,
    output logic         of_o
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [CW-1:0]      lz;
    logic [W-1:0]       sh_n;
    logic signed [9:0]  e_n;

    logic               s1_valid;
    logic               s1_sign;
    logic [W-1:0]       s1_sh;
    logic signed [9:0]  s1_e;
    logic               s1_zero;

    logic               s2_valid;
    logic [15:0]        s2_data;
    logic               s2_uf;
    logic               s2_of;

    logic               s1_load;
    logic               s2_load;

    logic [6:0]         frac;
    logic               g;
    logic               s;
    logic               rnd;
    logic [7:0]         frac_sum;
    logic signed [9:0]  e_r;
    logic [15:0]        data_n;
    logic               uf_n;
    logic               of_n;

    lzc #(.W(W)) u_lzc (
        .value (mant_i),
        .count (lz)
    );

    // Exponent stays in 10-bit two's complement so underflow/overflow remain visible.
    assign sh_n = mant_i << lz;
    assign e_n  = $signed(10'(exp_i) + 10'd1 - 10'(lz));

    assign s2_load = ~s2_valid | ready_i;
    assign s1_load = ~s1_valid | s2_load;
    assign ready_o = ~s1_valid | ~s2_valid | ready_i;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sh    <= '0;
            s1_e     <= '0;
            s1_zero  <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_sign <= sign_i;
                s1_sh   <= sh_n;
                s1_e    <= e_n;
                s1_zero <= (mant_i == '0);
            end
        end
    end

    always_comb begin
        frac     = s1_sh[W-2:W-8];
        g        = s1_sh[W-9];
        s        = |s1_sh[W-10:0];
        rnd      = g & (s | frac[0]);
        frac_sum = {1'b0, frac} + {7'd0, rnd};
        // Mantissa carry-out bumps the exponent before the range checks.
        e_r      = s1_e + (frac_sum[7] ? 10'sd1 : 10'sd0);
        data_n   = {s1_sign, 15'h0};
        uf_n     = 1'b0;
        of_n     = 1'b0;
        if (s1_zero) begin
            data_n = {s1_sign, 15'h0};
        end else if (e_r <= 10'sd0) begin
            uf_n   = 1'b1;
        end else if (e_r >= 10'sd255) begin
            data_n = {s1_sign, 8'hFF, 7'h0};
            of_n   = 1'b1;
        end else begin
            data_n = {s1_sign, e_r[7:0], frac_sum[6:0]};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_uf    <= 1'b0;
            s2_of    <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= data_n;
                s2_uf   <= uf_n;
                s2_of   <= of_n;
            end
        end
    end

    assign valid_o = s2_valid;
    assign data_o  = s2_data;
    assign uf_o    = s2_valid & s2_uf;
    assign of_o    = s2_valid & s2_of;

endmodule

// File: tb/tb_bf16_norm.sv
// Scoreboard bench for bf16_norm: expected words are queued on input handshake
// and compared when the DUT hands a beat downstream.

module tb_bf16_norm;

    localparam int W = 12;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [11:0] m;
    } beat_t;

    typedef struct {
        logic [15:0] data;
        logic        uf;
        logic        of;
        logic        lat;
        int          t0;
    } exp_t;

    logic         clk = 1'b0;
    logic         nreset;
    logic         valid_i;
    logic         ready_o;
    logic         sign_i;
    logic [7:0]   exp_i;
    logic [W-1:0] mant_i;
    logic         valid_o;
    logic         ready_i;
    logic [15:0]  data_o;
    logic         uf_o;
    logic         of_o;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    beat_t pend[$];
    exp_t  sb[$];

    bf16_norm #(.W(W)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sign_i  (sign_i),
        .exp_i   (exp_i),
        .mant_i  (mant_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .uf_o    (uf_o),
        .of_o    (of_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: locate MSB, align it to bit 20, round the bits below the 7-bit fraction.
    function automatic exp_t model(input beat_t b, input logic lat, input int t0);
        exp_t        r;
        int          p;
        int          ev;
        logic [31:0] mm;
        logic [6:0]  fr;
        logic [12:0] rest;
        logic        up;
        logic [7:0]  f8;
        r.lat = lat;
        r.t0  = t0;
        r.uf  = 1'b0;
        r.of  = 1'b0;
        r.data = {b.s, 15'h0};
        if (b.m == 12'h0) return r;
        p = 11;
        while (!b.m[p]) p--;
        mm   = 32'(b.m) << (20 - p);
        fr   = mm[19:13];
        rest = mm[12:0];
        ev   = int'(b.e) + p - 10;
        up   = (rest > 13'h1000) || ((rest == 13'h1000) && fr[0]);
        f8   = {1'b0, fr} + 8'(up);
        if (f8[7]) begin
            ev = ev + 1;
            fr = 7'h0;
        end else begin
            fr = f8[6:0];
        end
        if (ev <= 0) begin
            r.uf = 1'b1;
        end else if (ev >= 255) begin
            r.data = {b.s, 8'hFF, 7'h0};
            r.of   = 1'b1;
        end else begin
            r.data = {b.s, 8'(ev), fr};
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        #2;
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(data_o), 32'hDEAD);
            end else begin
                x = sb.pop_front();
                chk("data", 32'(data_o), 32'(x.data));
                chk("uf", 32'(uf_o), 32'(x.uf));
                chk("of", 32'(of_o), 32'(x.of));
                if (x.lat) chk("latency", 32'(cyc - x.t0), 32'd2);
            end
        end else if (!valid_o) begin
            chk("flags_idle", 32'({uf_o, of_o}), 32'd0);
        end
    end

    task automatic step(input logic rdy, input logic lat, output logic acc);
        beat_t b;
        @(negedge clk);
        ready_i = rdy;
        if (pend.size() > 0) begin
            valid_i = 1'b1;
            sign_i  = pend[0].s;
            exp_i   = pend[0].e;
            mant_i  = pend[0].m;
        end else begin
            valid_i = 1'b0;
        end
        #1;
        acc = valid_i && ready_o;
        if (acc) begin
            b = pend.pop_front();
            sb.push_back(model(b, lat, cyc));
        end
    endtask

    task automatic run(input logic lat);
        logic acc;
        for (int i = 0; i < 200 && (pend.size() > 0 || sb.size() > 0); i++)
            step(1'b1, lat, acc);
        chk("drain_timeout", 32'(pend.size() + sb.size()), 32'd0);
    endtask

    task automatic push(input logic s, input logic [7:0] e, input logic [11:0] m);
        beat_t b;
        b.s = s;
        b.e = e;
        b.m = m;
        pend.push_back(b);
    endtask

    initial begin
        logic        acc;
        logic [15:0] hold;

        nreset  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        sign_i  = 1'b0;
        exp_i   = '0;
        mant_i  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_flags", 32'({uf_o, of_o}), 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);

        chk("model_3f80", 32'(model('{1'b0, 8'd127, 12'h400}, 1'b0, 0).data), 32'h3F80);
        chk("model_7fc", 32'(model('{1'b0, 8'd127, 12'h7FC}, 1'b0, 0).data), 32'h4000);

        // Directed single beats, each checked for 2-cycle latency.
        push(1'b0, 8'd127, 12'h400); run(1'b1);
        push(1'b0, 8'd127, 12'h800); run(1'b1);
        push(1'b0, 8'd127, 12'h7FC); run(1'b1);
        push(1'b0, 8'd127, 12'h404); run(1'b1);
        push(1'b0, 8'd127, 12'h405); run(1'b1);
        push(1'b1, 8'd3,   12'h010); run(1'b1);
        push(1'b0, 8'd254, 12'h800); run(1'b1);
        push(1'b0, 8'd100, 12'h000); run(1'b1);
        push(1'b1, 8'd1,   12'h400); run(1'b1);
        push(1'b0, 8'd254, 12'h7FF); run(1'b1);

        // Backpressure: ready low for cycles 2..5 while 5 beats are offered.
        push(1'b0, 8'd120, 12'h400);
        push(1'b1, 8'd121, 12'h500);
        push(1'b0, 8'd122, 12'h600);
        push(1'b1, 8'd123, 12'h700);
        push(1'b0, 8'd124, 12'h7F0);
        step(1'b1, 1'b0, acc);
        step(1'b0, 1'b0, acc);
        step(1'b0, 1'b0, acc);
        chk("bp_absorbed", 32'(5 - pend.size()), 32'd2);
        chk("bp_ready", 32'(ready_o), 32'd0);
        chk("bp_valid", 32'(valid_o), 32'd1);
        hold = data_o;
        chk("bp_first", 32'(hold), 32'h3C00);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, acc);
            chk("bp_hold", 32'(data_o), 32'(hold));
            chk("bp_valid_hold", 32'(valid_o), 32'd1);
            chk("bp_absorbed_hold", 32'(5 - pend.size()), 32'd2);
        end
        run(1'b0);

        // Full throughput: random normalized beats back-to-back.
        for (int i = 0; i < 20; i++)
            push(1'($urandom), 8'($urandom_range(20, 230)), 12'($urandom_range(1, 4095)));
        run(1'b1);

        // Reset with two beats in flight.
        push(1'b0, 8'd127, 12'h400);
        push(1'b0, 8'd127, 12'h800);
        step(1'b1, 1'b0, acc);
        step(1'b1, 1'b0, acc);
        @(negedge clk);
        nreset  = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_o), 32'd0);
        chk("midrst_data", 32'(data_o), 32'd0);
        pend.delete();
        sb.delete();
        @(negedge clk);
        nreset = 1'b1;
        #1;
        chk("midrst_ready", 32'(ready_o), 32'd1);
        push(1'b1, 8'd130, 12'h405);
        run(1'b1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bf16_norm.md
# bf16_norm

Pipelined normalize-and-round stage for the BFloat16 datapath. It sits directly downstream of the `lzc` leading-zero counter, which it instantiates. It takes an unnormalized magnitude, biased exponent and sign from the adder/multiplier core. It emits a packed, round-to-nearest-even BF16 word, using a 2-stage valid/ready pipeline with full throughput and backpressure.

## Interface
- `W`, default 12: input mantissa width. Must be ≥ 10 (hidden bit, 7 fraction bits, guard, ≥1 sticky).
- `clk` input 1: clock, rising edge.
- `nreset` input 1: asynchronous active-low reset.
- `valid_i` input 1: input beat valid.
- `ready_o` output 1: stage can accept a beat this cycle.
- `sign_i` input 1: result sign.
- `exp_i` input 8: biased exponent (bias 127) of mantissa bit W-2.
- `mant_i` input W: unsigned magnitude. Bit W-1 is the carry position; bit W-2 is the nominal hidden-bit position.
- `valid_o` output 1: output beat valid.
- `ready_i` input 1: downstream accepts.
- `data_o` output 16: packed BF16 {sign, exp[7:0], frac[6:0]}.
- `uf_o` output 1: result flushed to zero by exponent underflow.
- `of_o` output 1: result saturated to infinity by exponent overflow.

## Operation
- **Stage 1 (normalize).** Registered on input handshake.
  - `c` = lzc(`mant_i`), range 0..W.
  - `sh` = `mant_i` << `c` (W bits; bit W-1 becomes the hidden bit).
  - `e` = `exp_i` + 1 − `c`, computed in 10-bit signed arithmetic, no wrap.
  - `zero` = (`mant_i` == 0).
- **Stage 2 (round and pack).**
  - `frac` = `sh`[W-2:W-8].
  - `g` = `sh`[W-9].
  - `s` = OR of `sh`[W-10:0].
  - `rnd` = `g` & (`s` | `frac`[0]) (round to nearest, ties to even).
  - `frac` + `rnd` carry-out: frac → 0, `e` → `e`+1. This adjustment is applied before the range checks.
- **Priority of results in stage 2:**
  1. `zero`: data = {sign, 15'h0}, `uf_o`=0, `of_o`=0.
  2. `e` ≤ 0: data = {sign, 15'h0}, `uf_o`=1. Subnormals are not produced.
  3. `e` ≥ 255: data = {sign, 8'hFF, 7'h0}, `of_o`=1.
  4. Otherwise: {sign, `e`[7:0], `frac`}.
- **Flags.** `uf_o`/`of_o` are qualified by `valid_o`; both are 0 whenever `valid_o`=0.
- **NaN/Inf inputs.** Out of scope; handled upstream.

## Timing
- **Latency.** 2 cycles from input handshake (`valid_i`&`ready_o`) to `valid_o` assertion.
- **Throughput.** 1 beat/cycle while `ready_i`=1.
- **Stage 2 register load.** Loads when `s2_valid`=0 or `ready_i`=1.
- **Stage 1 register load.** Loads when `s1_valid`=0 or stage 2 loads.
- **`ready_o`.** `ready_o` = ~`s1_valid` | ~`s2_valid` | `ready_i`. It is combinational from `ready_i`; no combinational path from `valid_i`.
- **Output stability.** `data_o`, `uf_o`, `of_o` and `valid_o` are held stable while `valid_o`=1 and `ready_i`=0.
- **Simultaneous events.** Accept at input and output in the same cycle with both stages full: both stages shift; no bubble, no loss.
- **Ordering.** Beats are never reordered or duplicated. Payload registers do not update on stages that do not load.
- **Reset values.** `valid_o`=0, `data_o`=16'h0, `uf_o`=0, `of_o`=0. Internal valids and payloads are cleared.
- **Reset mid-operation.** In-flight beats are discarded immediately (asynchronous). `ready_o`=1 in the first cycle after deassertion.

## Test plan
- **Basic normalize.** sign=0, exp_i=127, mant_i=12'h400 → data_o=16'h3F80, flags 0. mant_i=12'h800 → 16'h4000. Each appears exactly 2 cycles after accept.
- **Rounding.**
  - exp_i=127, mant_i=12'h7FC (tie, odd LSB) → round-up carries into exponent → 16'h4000.
  - mant_i=12'h404 (tie, even LSB) → 16'h3F80.
  - mant_i=12'h405 (above half) → 16'h3F81.
- **Underflow, overflow, zero.**
  - exp_i=3, mant_i=12'h010, sign=1 → 16'h8000 with uf_o=1.
  - exp_i=254, mant_i=12'h800 → 16'h7F80 with of_o=1.
  - mant_i=0 → 16'h0000 with both flags 0.
- **Backpressure.** Stream 5 beats back-to-back with ready_i held low for cycles 2–5.
  - Exactly 2 beats are absorbed and ready_o drops.
  - Outputs stay stable while stalled.
  - On ready_i=1, all 5 beats emerge in order with no loss or duplication.
- **Full throughput.** 20 random normalized beats with ready_i=1 → one output per cycle. Each output matches a reference model of the normalize/round/range rules above.
- **Reset mid-stream.** Assert nreset with 2 beats in flight → valid_o=0 and data_o=0 immediately. After release, the first new beat completes with 2-cycle latency.
